// File: rtl/stack_sequencer_if.sv
// Request, data-memory and result signals of the stack sequencer.
// slave is the sequencer side; master is the pipeline/memory side.
interface stack_sequencer_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic        req_ready;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic [15:0] reg_in;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;
    logic [31:0] sp_out;
    logic [15:0] pop_reg;
    logic [31:0] pop_pc;
    logic [3:0]  pop_flags;
    logic        done;
    logic        stk_err;

    modport slave (
        input  req_valid, req_op, pc_in, flags_in, reg_in, mem_rdata,
        output req_ready, mem_addr, mem_we, mem_re, mem_wdata, stall,
               sp_out, pop_reg, pop_pc, pop_flags, done, stk_err
    );

    modport master (
        output req_valid, req_op, pc_in, flags_in, reg_in, mem_rdata,
        input  req_ready, mem_addr, mem_we, mem_re, mem_wdata, stall,
               sp_out, pop_reg, pop_pc, pop_flags, done, stk_err
    );
endinterface

// File: rtl/stack_sequencer.sv
// Stack-pointer owner: splits PUSH/POP/CALL/RET/INT/RTI into 16-bit memory beats.
// Pushes write then decrement; pops increment and read SP+1, with data one cycle later.
module stack_sequencer #(
    parameter logic [31:0] SP_INIT = 32'h000F_FFFF
) (
    input  logic clk,
    input  logic rst,
    stack_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, DONE} state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    function automatic logic [1:0] beats(input logic [2:0] op);
        case (op)
            OP_PUSH, OP_POP: beats = 2'd1;
            OP_CALL, OP_RET: beats = 2'd2;
            default:         beats = 2'd3;
        endcase
    endfunction

    state_t      state, state_d;
    logic [31:0] sp;
    logic [2:0]  op_q;
    logic [31:0] pc_q;
    logic [3:0]  flags_q;
    logic [15:0] reg_q;
    logic [1:0]  beat;
    logic        err_q;
    logic        cap_vld;
    logic [1:0]  cap_idx;
    logic [15:0] pop_reg_q;
    logic [31:0] pop_pc_q;
    logic [3:0]  pop_flags_q;

    logic        accept, req_is_pop, underflow, last_beat;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, wr_word;
    logic        mem_we, mem_re;

    assign accept     = bus.req_valid && (state == IDLE) && (bus.req_op <= OP_RTI);
    assign req_is_pop = (bus.req_op == OP_POP) || (bus.req_op == OP_RET) || (bus.req_op == OP_RTI);
    assign underflow  = (SP_INIT - sp) < {30'd0, beats(bus.req_op)};
    assign last_beat  = (beat == beats(op_q) - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        mem_addr  = 32'd0;
        mem_wdata = 16'd0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        // First beat of CALL/INT carries the PC high half; INT ends with flags.
        case (op_q)
            OP_PUSH: wr_word = reg_q;
            OP_CALL: wr_word = (beat == 2'd0) ? pc_q[31:16] : pc_q[15:0];
            default: wr_word = (beat == 2'd0) ? pc_q[31:16] :
                               (beat == 2'd1) ? pc_q[15:0]  : {12'd0, flags_q};
        endcase
        case (state)
            IDLE: if (accept) begin
                if (req_is_pop) state_d = underflow ? DONE : RD;
                else            state_d = WR;
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = wr_word;
                if (last_beat) state_d = DONE;
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = sp + 32'd1;
                if (last_beat) state_d = WAIT;
            end
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp          <= SP_INIT;
            op_q        <= 3'd0;
            pc_q        <= 32'd0;
            flags_q     <= 4'd0;
            reg_q       <= 16'd0;
            beat        <= 2'd0;
            err_q       <= 1'b0;
            cap_vld     <= 1'b0;
            cap_idx     <= 2'd0;
            pop_reg_q   <= 16'd0;
            pop_pc_q    <= 32'd0;
            pop_flags_q <= 4'd0;
        end else begin
            cap_vld <= (state == RD);
            cap_idx <= beat;
            if (accept) begin
                op_q    <= bus.req_op;
                pc_q    <= bus.pc_in;
                flags_q <= bus.flags_in;
                reg_q   <= bus.reg_in;
                beat    <= 2'd0;
                err_q   <= req_is_pop && underflow;
            end
            if (state == WR) begin
                sp   <= sp - 32'd1;
                beat <= beat + 2'd1;
            end
            if (state == RD) begin
                sp   <= sp + 32'd1;
                beat <= beat + 2'd1;
            end
            // Read data lands one cycle after its beat, so WAIT collects the last word.
            if (cap_vld) begin
                case (op_q)
                    OP_POP: pop_reg_q <= bus.mem_rdata;
                    OP_RET: if (cap_idx == 2'd0) pop_pc_q[15:0]  <= bus.mem_rdata;
                            else                 pop_pc_q[31:16] <= bus.mem_rdata;
                    OP_RTI: if (cap_idx == 2'd0)      pop_flags_q     <= bus.mem_rdata[3:0];
                            else if (cap_idx == 2'd1) pop_pc_q[15:0]  <= bus.mem_rdata;
                            else                      pop_pc_q[31:16] <= bus.mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.stall     = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.stk_err   = (state == DONE) && err_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;
    assign bus.mem_re    = mem_re;
    assign bus.sp_out    = sp;
    assign bus.pop_reg   = pop_reg_q;
    assign bus.pop_pc    = pop_pc_q;
    assign bus.pop_flags = pop_flags_q;
endmodule
